bist_sig_controller: RTL

//  Sequencer for one BIST session. Sits downstream of the response MISR:
//  - clears the MISR
//  - enables it, and the upstream pattern generator, for a programmed number of cycles
//  - compares the final signature against a golden value and reports pass/fail.

---
 rtl/bist_sig_controller.sv | 123 ++++++++++++
 1 files changed

// File: rtl/bist_sig_controller.sv
// BIST session sequencer: clears the MISR, runs it for a programmed number of cycles,
// then compares the signature against a golden value. Define BIST_SIG_CAPTURE_EN to add the sig_out capture register.
module bist_sig_controller #(
    parameter int N     = 120,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] pattern_count,
    input  logic [N:0]       golden_sig,
    input  logic [N:0]       misr_q,
    output logic             misr_reset,
    output logic             misr_enable,
    output logic             pgen_enable,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N:0]       sig_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_SETTLE,
        S_CMP,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_misr_reset;
    logic             r_run_en;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    logic w_accept;
    logic w_match;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_match  = (misr_q == golden_sig);

    // NOTE: state lives in flops assigned with <= only; the asynchronous reset also
    // drops misr_enable immediately, which is the only non-clocked enable change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_misr_reset <= 1'b0;
            r_run_en     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            r_misr_reset <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_state <= S_CLR;
                        r_count <= pattern_count;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                    end
                end
                S_CLR: begin
                    r_misr_reset <= 1'b1;
                    r_state      <= (r_count != '0) ? S_RUN : S_SETTLE;
                end
                S_RUN: begin
                    // One enabled cycle per remaining pattern; the edge after the last drops the enables.
                    if (r_count != '0) begin
                        r_run_en <= 1'b1;
                        r_count  <= r_count - CNT_W'(1);
                    end else begin
                        r_run_en <= 1'b0;
                        r_state  <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    r_state <= S_CMP;
                end
                S_CMP: begin
                    r_pass  <= w_match;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign misr_reset  = r_misr_reset;
    assign misr_enable = r_run_en;
    assign pgen_enable = r_run_en;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;

`ifdef BIST_SIG_CAPTURE_EN
    logic [N:0] r_sig;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sig <= '0;
        end else if (w_accept) begin
            r_sig <= '0;
        end else if (r_state == S_CMP) begin
            r_sig <= misr_q;
        end
    end

    assign sig_out = r_sig;
`else
    assign sig_out = '0;
`endif

endmodule
